// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op port for two's-complement division.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             dz, q_neg, r_neg, a_neg, b_neg, zero, accept, last;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag   = a_neg ? -dividend : dividend;
    assign b_mag   = b_neg ? -divisor : divisor;
    assign zero    = divisor == '0;
    // busy lags the state by one cycle, so it still covers the done cycle
    assign accept  = state == IDLE && start && !busy;
    assign last    = cnt == CW'(WIDTH - 1);
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) state_nx = accept ? (zero ? DONE : CALC) : IDLE;
        else if (state == CALC) state_nx = last ? DONE : CALC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            dz          <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= state != IDLE;
            done <= state == DONE;
            if (accept) begin
                cnt   <= '0;
                dvs   <= b_mag;
                dz    <= zero;
                q_neg <= !zero & (a_neg ^ b_neg);
                r_neg <= !zero & a_neg;
                rem   <= zero ? dividend : '0;
                quo   <= zero ? '1 : a_mag;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], !trial[WIDTH]};
            end else if (state == DONE) begin
                quotient    <= q_neg ? -quo : quo;
                remainder   <= r_neg ? -rem : rem;
                div_by_zero <= dz;
            end
        end
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider: one quotient bit per clock. It is the inverse-operation companion to the ALU multiplier.
- Accepts dividend and divisor on a start pulse and returns quotient and remainder with a done pulse.
- Sits beside the multiplier under the ALU and shares its register-stage style: plain posedge flops, one clock.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).
- CW, 6, iteration counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  clock, posedge active.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator, sampled with start.
- divisor  input  WIDTH  denominator, sampled with start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered result; held until next done.
- remainder  output  WIDTH  registered result; held until next done.
- div_by_zero  output  1  registered flag; updated with done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, and all internal regs cleared. All outputs go to 0: busy, done, quotient, remainder, div_by_zero.
- A reset mid-operation aborts the operation. No done is issued for the aborted operation.
- IDLE:
  - busy=0.
  - On a posedge with start=1 and divisor!=0: latch operands, clear the partial remainder, counter=0, go to CALC.
  - On a posedge with start=1 and divisor==0: go directly to DONE with the result preset to quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC: each edge performs one restoring step:
  - shift {rem,quo} left by 1, bringing in the dividend MSB;
  - trial = rem - divisor, computed at WIDTH+1 bits;
  - if trial is non-negative, rem=trial and the quotient LSB=1, else the quotient LSB=0;
  - counter increments; after step WIDTH (counter==WIDTH-1) go to DONE.
- DONE:
  - Load the quotient/remainder/div_by_zero output registers.
  - done=1 for exactly this cycle; then go to IDLE.
- Latency, counting edge 0 as the edge that samples start:
  - normal case: done is high in the cycle following edge WIDTH+1;
  - divide-by-zero: done is high in the cycle following edge 1.
- Back-to-back operation: start may be asserted in the cycle where done=1, but it is ignored because busy=1. The earliest accepted start is the cycle after done.
- start while busy=1 is ignored. Operands changing while busy have no effect.
- Outputs update only in DONE. Otherwise they hold the previous result.
- Arithmetic is unsigned, truncating. The invariant dividend = quotient*divisor + remainder holds with remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), sampled with start.
  - When signed_op=1, operands are two's complement. Magnitudes are divided unsigned and signs are fixed in DONE.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Overflow case MIN / -1 gives quotient=MIN, remainder=0, div_by_zero=0.
  - Divide-by-zero gives the same results as the unsigned case.
  - Latency is unchanged.
- Undefined: the signed_op port does not exist and the block is unsigned only.

Test Plan:
- dividend=100, divisor=7, start for 1 cycle -> done after edge 33; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 33 cycles.
- dividend=5, divisor=0 -> done after edge 1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- dividend=0xFFFFFFFF, divisor=1, then dividend=3, divisor=0x80000000 -> first result q=0xFFFFFFFF r=0; second result q=0 r=3.
- Start 100/7, then at edge 10 pulse start with 9/3 -> second request ignored; result q=14 r=2; only one done pulse.
- Start 100/7, drive rst=0 at edge 15 -> busy and all outputs read 0 immediately with no clock edge. Release rst, then start 81/9 -> q=9 r=0 after edge 33.
- (SEQ_DIVIDER_SIGNED_EN, signed_op=1) -7/2 -> q=0xFFFFFFFD r=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> q=0x80000000 r=0.
